// File: rtl/regfile_wb_arbiter.sv
// Shares the RegFile write port: W stage wins with zero latency, long-unit results wait >=1 cycle in a FIFO.
// lu_ready drops only when the FIFO is full; pipe_hold asks the pipeline for bubbles once the FIFO head starves.
module regfile_wb_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_w_ena,
  input  logic [4:0]  pipe_w_addr,
  input  logic [31:0] pipe_w_data,
  input  logic        lu_issue,
  input  logic [4:0]  lu_issue_addr,
  input  logic        lu_valid,
  input  logic [4:0]  lu_addr,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  input  logic [4:0]  rd_rs_addr,
  input  logic [4:0]  rd_rt_addr,
  output logic        hazard_stall,
  output logic        pipe_hold,
  output logic        rf_w_ena,
  output logic [4:0]  rf_w_addr,
  output logic [31:0] rf_w_data
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [PW:0]   DEPTH_C = (PW + 1)'(FIFO_DEPTH);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_t;

  wb_t           mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic [31:0]   busy;
  logic [31:0]   busy_nxt;
  logic [SW-1:0] starve_cnt;
  wb_t           head;
  logic          fifo_nempty;
  logic          push;
  logic          pop;
  logic          rs_wait;
  logic          rt_wait;

  assign head        = mem[rd_ptr];
  assign fifo_nempty = (count != '0);
  assign lu_ready    = !rst && (count < DEPTH_C);
  assign push        = lu_valid && lu_ready;
  assign pop         = !rst && !pipe_w_ena && fifo_nempty;

  always_comb begin
    rf_w_ena  = 1'b0;
    rf_w_addr = '0;
    rf_w_data = '0;
    if (!rst) begin
      if (pipe_w_ena) begin
        rf_w_ena  = 1'b1;
        rf_w_addr = pipe_w_addr;
        rf_w_data = pipe_w_data;
      end else if (fifo_nempty) begin
        rf_w_ena  = 1'b1;
        rf_w_addr = head.addr;
        rf_w_data = head.data;
      end
    end
  end

  // A register being popped this cycle is not a hazard: the RegFile forwards the write to its read ports.
  assign rs_wait      = (rd_rs_addr != 5'd0) && busy[rd_rs_addr] && !(pop && head.addr == rd_rs_addr);
  assign rt_wait      = (rd_rt_addr != 5'd0) && busy[rd_rt_addr] && !(pop && head.addr == rd_rt_addr);
  assign hazard_stall = !rst && (rs_wait || rt_wait);
  assign pipe_hold    = !rst && (starve_cnt == LIMIT_C);

  // Issue is applied after the pop clear so a same-cycle set of the same register wins.
  always_comb begin
    busy_nxt = busy;
    if (pop) busy_nxt[head.addr] = 1'b0;
    if (lu_issue && lu_issue_addr != 5'd0) busy_nxt[lu_issue_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {lu_addr, lu_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      busy       <= '0;
      starve_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      busy <= busy_nxt;
      if (pop || !fifo_nempty)                         starve_cnt <= '0;
      else if (pipe_w_ena && starve_cnt != LIMIT_C)   starve_cnt <= starve_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboarded bench: a queue-based model predicts every RegFile write; a negedge monitor pops and compares.
module tb_regfile_wb_arbiter;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_w_ena;
  logic [4:0]  pipe_w_addr;
  logic [31:0] pipe_w_data;
  logic        lu_issue;
  logic [4:0]  lu_issue_addr;
  logic        lu_valid;
  logic [4:0]  lu_addr;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic [4:0]  rd_rs_addr;
  logic [4:0]  rd_rt_addr;
  logic        hazard_stall;
  logic        pipe_hold;
  logic        rf_w_ena;
  logic [4:0]  rf_w_addr;
  logic [31:0] rf_w_data;

  regfile_wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .pipe_w_ena(pipe_w_ena), .pipe_w_addr(pipe_w_addr), .pipe_w_data(pipe_w_data),
    .lu_issue(lu_issue), .lu_issue_addr(lu_issue_addr),
    .lu_valid(lu_valid), .lu_addr(lu_addr), .lu_data(lu_data), .lu_ready(lu_ready),
    .rd_rs_addr(rd_rs_addr), .rd_rt_addr(rd_rt_addr),
    .hazard_stall(hazard_stall), .pipe_hold(pipe_hold),
    .rf_w_ena(rf_w_ena), .rf_w_addr(rf_w_addr), .rf_w_data(rf_w_data)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] a; logic [31:0] d; } res_t;
  typedef struct { int cyc; logic [4:0] a; logic [31:0] d; } exp_t;

  int   tests = 0;
  int   fails = 0;
  int   cycle = 0;
  exp_t exp_q[$];
  res_t pend[$];     // results accepted by the arbiter, not yet written
  res_t lu_src[$];   // results the long unit wants to deliver, in order
  bit   busy_m[32];
  bit   outst[32];   // issued, result not yet produced
  int   blocked = 0;

  always @(posedge clk) cycle++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cycle, act, req);
    end
  endtask

  function automatic bit waits(input logic [4:0] r, input bit pop_e, input logic [4:0] ha);
    return (r != 5'd0) && busy_m[r] && !(pop_e && ha == r);
  endfunction

  task automatic give(input logic [4:0] a, input logic [31:0] d);
    assert (busy_m[a]);
    lu_src.push_back('{a: a, d: d});
    outst[a] = 1'b0;
  endtask

  // One clock cycle: drive inputs, predict outputs, then advance the model across the edge.
  task automatic cyc(input bit r, input bit pe, input logic [4:0] pa, input logic [31:0] pd,
                     input bit iss, input logic [4:0] ia, input logic [4:0] rs, input logic [4:0] rt,
                     input bit obey = 1'b1);
    bit   hold_e, rdy_e, pop_e, lv, haz_e;
    int   had;
    res_t h;
    h      = '{a: 5'd0, d: 32'd0};
    hold_e = !r && (blocked >= LIMIT);
    if (obey && hold_e) pe = 1'b0;
    lv = !r && (lu_src.size() > 0);
    if (pe) assert (!busy_m[pa]);
    if (iss && ia != 5'd0) assert (!busy_m[ia]);
    rst = r; pipe_w_ena = pe; pipe_w_addr = pa; pipe_w_data = pd;
    lu_issue = iss; lu_issue_addr = ia; rd_rs_addr = rs; rd_rt_addr = rt;
    lu_valid = lv;
    lu_addr  = lv ? lu_src[0].a : 5'd0;
    lu_data  = lv ? lu_src[0].d : 32'd0;
    rdy_e = !r && (pend.size() < DEPTH);
    pop_e = !r && !pe && (pend.size() > 0);
    if (pop_e) h = pend[0];
    if (pe && !r)  exp_q.push_back('{cyc: cycle, a: pa, d: pd});
    else if (pop_e) exp_q.push_back('{cyc: cycle, a: h.a, d: h.d});
    haz_e = !r && (waits(rs, pop_e, h.a) || waits(rt, pop_e, h.a));
    #3;
    chk("lu_ready", 64'(lu_ready), 64'(rdy_e));
    chk("hazard_stall", 64'(hazard_stall), 64'(haz_e));
    chk("pipe_hold", 64'(pipe_hold), 64'(hold_e));
    if (r) chk("rst_wr_addr_data", 64'({rf_w_addr, rf_w_data}), 64'd0);
    @(posedge clk);
    if (r) begin
      pend.delete(); lu_src.delete();
      busy_m = '{default: 1'b0}; outst = '{default: 1'b0};
      blocked = 0;
    end else begin
      had = pend.size();
      if (pop_e) begin pend.delete(0); busy_m[h.a] = 1'b0; end
      if (iss && ia != 5'd0) begin busy_m[ia] = 1'b1; outst[ia] = 1'b1; end
      if (lv && rdy_e) begin pend.push_back(lu_src[0]); lu_src.delete(0); end
      if (had == 0 || pop_e) blocked = 0;
      else if (blocked < LIMIT) blocked++;
    end
    #1;
  endtask

  task automatic idle(input int n, input logic [4:0] rs = 5'd0, input logic [4:0] rt = 5'd0);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, rs, rt);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rf_w_ena) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_write cycle %0d: got r%0d=%0h, expected no write", cycle, rf_w_addr, rf_w_data);
        end else begin
          e = exp_q.pop_front();
          chk("wr_cycle", 64'(cycle), 64'(e.cyc));
          chk("wr_addr_data", 64'({rf_w_addr, rf_w_data}), 64'({e.a, e.d}));
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cycle) begin
        e = exp_q.pop_front();
        tests++; fails++;
        $display("FAIL missed_write cycle %0d: got none, expected r%0d=%0h", cycle, e.a, e.d);
      end
    end
  end

  initial begin : driver
    rst = 1'b1; pipe_w_ena = 1'b0; pipe_w_addr = '0; pipe_w_data = '0;
    lu_issue = 1'b0; lu_issue_addr = '0; lu_valid = 1'b0; lu_addr = '0; lu_data = '0;
    rd_rs_addr = '0; rd_rt_addr = '0;
    #1;
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    cyc(1'b1, 1'b1, 5'd2, 32'h55, 1'b0, 5'd0, 5'd0, 5'd0);

    // Pipe-only write, then quiet.
    cyc(1'b0, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 5'd0, 5'd0);
    idle(2);

    // Issue r9, result two cycles later, rs=9 held.
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd0);
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd0);
    give(5'd9, 32'hDEADBEEF);
    idle(3, 5'd9);

    // Collision: r3 buffered while pipe writes r4 three times.
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd0, 5'd0);
    give(5'd3, 32'hA);
    idle(1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 5'd4, 32'h400 + i, 1'b0, 5'd0, 5'd3, 5'd0);
    idle(2, 5'd3);

    // Full FIFO, back-pressure and starvation hold under continuous pipe writes.
    for (int i = 1; i <= 3; i++) cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 5'd0, 5'd0);
    give(5'd1, 32'h1111); give(5'd2, 32'h2222); give(5'd3, 32'h3333);
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, 5'd4, 32'h900 + i, 1'b0, 5'd0, 5'd1, 5'd3);
    idle(4, 5'd2, 5'd3);

    // Reset with two buffered results.
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd0, 5'd0);
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 5'd0, 5'd0);
    give(5'd7, 32'h77); give(5'd8, 32'h88);
    cyc(1'b0, 1'b1, 5'd4, 32'hB0, 1'b0, 5'd0, 5'd7, 5'd8);
    cyc(1'b0, 1'b1, 5'd4, 32'hB1, 1'b0, 5'd0, 5'd7, 5'd8);
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd8);
    idle(3, 5'd7, 5'd8);

    // Randomized traffic on a small register window to force overlaps.
    for (int n = 0; n < 3000; n++) begin
      bit r, pe, iss;
      logic [4:0] pa, ia;
      int k0;
      r   = ($urandom_range(0, 299) == 0);
      pe  = 1'($urandom_range(0, 1));
      pa  = 5'($urandom_range(0, 7));
      if (busy_m[pa]) pe = 1'b0;
      iss = ($urandom_range(0, 3) == 0);
      ia  = 5'($urandom_range(0, 7));
      if (busy_m[ia]) iss = 1'b0;
      if ($urandom_range(0, 2) == 0) begin
        k0 = $urandom_range(0, 31);
        for (int k = 0; k < 32; k++) begin
          if (outst[(k0 + k) % 32]) begin
            give(5'((k0 + k) % 32), $urandom);
            break;
          end
        end
      end
      cyc(r, pe, pa, $urandom, iss, ia, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
          ($urandom_range(0, 9) != 0));
    end
    idle(8);
    chk("exp_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
